wr_port_arbiter: RTL and testbench

//  Shares the single write port of the async FIFO (wr_en_sys/data, wr_clk domain) among NUM_REQ requesters.

---
 rtl/wr_arb_pkg.sv | 15 +
 rtl/wr_port_arbiter_rr_pick.sv | 39 +++
 rtl/wr_port_arbiter.sv | 118 +++++++++++
 tb/tb_wr_port_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wr_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM encoding (idle / port locked to one requester)
//   gid_width() : width of a requester index for a given requester count
package wr_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans requesters starting one past last_grant and wrapping, returns the
// first asserted index.
//   req        in   N    request vector
//   last_grant in   GW   index granted most recently
//   pick_valid out  1    at least one request asserted
//   pick_idx   out  GW   winning index (0 when pick_valid=0)
module rr_pick
    import wr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = gid_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic          pick_valid,
    output logic [GW-1:0] pick_idx
);

    int            cand;
    logic [GW-1:0] cand_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        // k runs 1..N so last_grant itself is checked last.
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(last_grant) + k) % N;
            cand_idx = GW'(cand);
            if (!pick_valid && req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Shares the async FIFO write port among NUM_REQ requesters.
// Round-robin arbitration with packet lock: the owner keeps the port until
// its last beat or MAX_BURST beats, whichever comes first.
//   wr_clk     in   1                   write-domain clock
//   rst_n      in   1                   synchronous active-low reset
//   req_valid  in   NUM_REQ             per-requester data valid
//   req_last   in   NUM_REQ             per-requester last beat of packet
//   req_data   in   NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  NUM_REQ             one-hot or zero
//   full       in   1                   FIFO full flag
//   wr_en_sys  out  1                   FIFO write request
//   wr_data    out  DATA_WIDTH          FIFO write data
//   grant_id   out  GID_WIDTH           current owner (valid while busy)
//   busy       out  1                   port locked to grant_id
//
// state   | meaning
// IDLE    | no owner; arbitrate among valid requesters (no data accepted)
// LOCK    | port owned by grant_id; beats pass through until release
module wr_port_arbiter
    import wr_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 8,
    parameter  int CNT_WIDTH  = 4,
    localparam int GID_WIDTH  = gid_width(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr_en_sys,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [GID_WIDTH-1:0]          grant_id,
    output logic                          busy
);

    localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(MAX_BURST - 1);

    arb_state_e           state_q, state_d;
    logic [GID_WIDTH-1:0] grant_q, grant_d;
    logic [GID_WIDTH-1:0] last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 pick_valid;
    logic [GID_WIDTH-1:0] pick_idx;

    rr_pick #(
        .N  (NUM_REQ),
        .GW (GID_WIDTH)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Handshake outputs are gated by rst_n directly so nothing is written
    // in a reset cycle even while the registers still show LOCK.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready    = '0;
        wr_en_sys    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_LOCK;
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_LOCK: begin
                req_ready[grant_q] = ~full & rst_n;
                wr_en_sys          = req_valid[grant_q] & ~full & rst_n;
                if (wr_en_sys) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (req_last[grant_q] || (beat_cnt_q == BURST_LAST)) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GID_WIDTH'(i)) begin
                wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_wr_port_arbiter.sv
module tb_wr_port_arbiter;

    logic        wr_clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        wr_en_sys;
    logic [7:0]  wr_data;
    logic [1:0]  grant_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    wr_port_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (8),
        .CNT_WIDTH  (4)
    ) dut (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en_sys (wr_en_sys),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        full      = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 8'hA0 + 8'(i));

        // Reset held 3 cycles with every requester valid
        repeat (3) begin
            tick(); #1;
            chk("rst_wren", wr_en_sys, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
        end

        // Fairness: 1-beat packets from all four, grant 0,1,2,3,0
        tick(); rst_n = 1'b1; #1;
        chk("fair_idle_busy", busy, 0);
        chk("fair_idle_wren", wr_en_sys, 0);
        for (int n = 0; n < 5; n++) begin
            if (n > 0) begin
                tick(); #1;
                chk("fair_bubble", wr_en_sys, 0);
            end
            tick(); #1;
            chk("fair_grant", grant_id, n % 4);
            chk("fair_wren", wr_en_sys, 1);
            chk("fair_data", wr_data, 8'hA0 + 8'(n % 4));
            chk("fair_ready", req_ready, 4'b0001 << (n % 4));
        end

        // Packet lock: req1 3-beat packet while req0/req2 valid
        tick(); req_valid = 4'b0111; req_last = 4'b0101; #1;
        chk("lock_bubble", wr_en_sys, 0);
        for (int b = 0; b < 3; b++) begin
            tick();
            set_data(1, 8'h11 + 8'(b));
            req_last[1] = (b == 2);
            #1;
            chk("lock_grant", grant_id, 1);
            chk("lock_wren", wr_en_sys, 1);
            chk("lock_data", wr_data, 8'h11 + 8'(b));
        end
        tick(); #1;
        chk("lock_release_busy", busy, 0);
        tick(); #1;
        chk("lock_next_grant", grant_id, 2);
        chk("lock_next_wren", wr_en_sys, 1);
        chk("lock_next_data", wr_data, 8'hA2);
        tick(); req_valid = 4'b0000; #1;
        chk("lock_idle_busy", busy, 0);

        // Burst limit: req0 12-beat packet, req3 waiting
        tick(); req_valid = 4'b0001; req_last = 4'b1000; #1;
        chk("burst_bubble", wr_en_sys, 0);
        for (int b = 0; b < 8; b++) begin
            tick();
            req_valid = 4'b1001;
            set_data(0, 8'h40 + 8'(b));
            #1;
            chk("burst_grant", grant_id, 0);
            chk("burst_wren", wr_en_sys, 1);
            chk("burst_data", wr_data, 8'h40 + 8'(b));
        end
        tick(); #1;
        chk("burst_forced_release", busy, 0);
        tick(); #1;
        chk("burst_req3_grant", grant_id, 3);
        chk("burst_req3_wren", wr_en_sys, 1);
        chk("burst_req3_data", wr_data, 8'hA3);
        tick(); #1;
        chk("burst_req3_bubble", wr_en_sys, 0);
        for (int b = 0; b < 4; b++) begin
            tick();
            set_data(0, 8'h48 + 8'(b));
            req_last[0] = (b == 3);
            #1;
            chk("burst_resume_grant", grant_id, 0);
            chk("burst_resume_wren", wr_en_sys, 1);
            chk("burst_resume_data", wr_data, 8'h48 + 8'(b));
        end

        // Full back-pressure at beat 2, then owner drops valid one cycle
        tick(); req_valid = 4'b0001; req_last = 4'b0000; #1;
        chk("full_bubble", wr_en_sys, 0);
        for (int b = 0; b < 2; b++) begin
            tick(); set_data(0, 8'h60 + 8'(b)); #1;
            chk("full_pre_wren", wr_en_sys, 1);
            chk("full_pre_data", wr_data, 8'h60 + 8'(b));
        end
        for (int k = 0; k < 4; k++) begin
            tick(); full = 1'b1; set_data(0, 8'h62); #1;
            chk("full_wren", wr_en_sys, 0);
            chk("full_ready", req_ready, 0);
            chk("full_busy", busy, 1);
            chk("full_grant", grant_id, 0);
            chk("full_cnt", dut.beat_cnt_q, 2);
        end
        tick(); full = 1'b0; req_valid = 4'b0000; #1;
        chk("drop_wren", wr_en_sys, 0);
        chk("drop_busy", busy, 1);
        chk("drop_ready", req_ready, 4'b0001);
        tick(); req_valid = 4'b0001; req_last = 4'b0001; #1;
        chk("full_resume_wren", wr_en_sys, 1);
        chk("full_resume_data", wr_data, 8'h62);
        chk("full_resume_cnt", dut.beat_cnt_q, 2);
        tick(); req_valid = 4'b0000; req_last = 4'b0000; #1;
        chk("full_done_busy", busy, 0);

        // Reset mid-burst: req1 owns the port, reset at its beat 3
        tick(); req_valid = 4'b0011; set_data(0, 8'hA0); #1;
        chk("rstmid_bubble", wr_en_sys, 0);
        for (int b = 0; b < 2; b++) begin
            tick(); set_data(1, 8'h70 + 8'(b)); #1;
            chk("rstmid_grant", grant_id, 1);
            chk("rstmid_pre_wren", wr_en_sys, 1);
        end
        tick(); rst_n = 1'b0; #1;
        chk("rstmid_wren", wr_en_sys, 0);
        chk("rstmid_ready", req_ready, 0);
        tick(); rst_n = 1'b1; #1;
        chk("rstmid_idle_busy", busy, 0);
        chk("rstmid_idle_wren", wr_en_sys, 0);
        tick(); #1;
        chk("rstmid_first_grant", grant_id, 0);
        chk("rstmid_first_busy", busy, 1);
        chk("rstmid_first_wren", wr_en_sys, 1);
        chk("rstmid_first_data", wr_data, 8'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
